// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with a 2-entry skid buffer, flush-to-NOP and occupancy
module pipe_skid_stage #(
    parameter int DATA_W = 96,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_in_fire;
    logic              w_out_fire;

    // in_ready is decoded from r_state alone so out_ready never reaches it combinationally
    assign in_ready   = r_state != FULL;
    assign out_valid  = r_state != EMPTY;
    assign out_data   = out_valid ? r_main : NOP_VALUE;
    assign occupancy  = r_state;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= EMPTY;
            r_main  <= NOP_VALUE;
            r_skid  <= NOP_VALUE;
        end else if (r_state == EMPTY) begin
            if (w_in_fire) begin
                r_state <= ONE;
                r_main  <= in_data;
            end
        end else if (r_state == ONE) begin
            if (w_in_fire && !w_out_fire) begin
                r_state <= FULL;
                r_skid  <= in_data;
            end else if (w_in_fire) begin
                r_main  <= in_data;
            end else if (w_out_fire) begin
                r_state <= EMPTY;
                r_main  <= NOP_VALUE;
            end
        end else if (w_out_fire) begin
            r_state <= ONE;
            r_main  <= r_skid;
            r_skid  <= NOP_VALUE;
        end
    end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: queue-model check of three stage variants sharing one stimulus stream
module tb_pipe_skid_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [95:0] in_data = '0;
    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [95:0] out_data_a, out_data_b;
    logic [0:0]  out_data_c;
    logic [1:0]  occ_a, occ_b, occ_c;
    logic [95:0] mq[$];
    logic        armed = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_stage dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .occupancy(occ_a)
    );

    pipe_skid_stage #(.DATA_W(96), .NOP_VALUE(96'h13)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .occupancy(occ_b)
    );

    pipe_skid_stage #(.DATA_W(1), .NOP_VALUE(1'b1)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data[0:0]), .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .occupancy(occ_c)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: the stage is a FIFO of depth 2 whose head is visible, emptied by reset/flush
    always @(posedge clk) begin : model
        bit ofire, ifire;
        if (reset || flush) begin
            mq.delete();
            if (reset) armed <= 1'b1;
        end else begin
            ofire = mq.size() > 0 && out_ready;
            ifire = in_valid && mq.size() < 2;
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin : compare
        int n;
        logic [95:0] h;
        if (armed) begin
            n = mq.size();
            h = n > 0 ? mq[0] : 96'h0;
            chk("occ_a", {94'd0, occ_a}, 96'(n));
            chk("occ_b", {94'd0, occ_b}, 96'(n));
            chk("occ_c", {94'd0, occ_c}, 96'(n));
            chk("in_ready_a", {95'd0, in_ready_a}, {95'd0, n < 2});
            chk("in_ready_c", {95'd0, in_ready_c}, {95'd0, n < 2});
            chk("out_valid_a", {95'd0, out_valid_a}, {95'd0, n > 0});
            chk("out_valid_c", {95'd0, out_valid_c}, {95'd0, n > 0});
            chk("out_data_a", out_data_a, n > 0 ? h : 96'h0);
            chk("out_data_b", out_data_b, n > 0 ? h : 96'h13);
            chk("out_data_c", {95'd0, out_data_c}, {95'd0, n > 0 ? h[0] : 1'b1});
        end
    end

    task automatic drive(input logic iv, input logic [95:0] id, input logic ordy,
                         input logic fl, input logic rst);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pv, pr;
        // 1: reset then stream
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 1);
        chk("t1 rst valid", {95'd0, out_valid_a}, 96'd0);
        chk("t1 rst ready", {95'd0, in_ready_a}, 96'd1);
        chk("t1 rst occ", {94'd0, occ_a}, 96'd0);
        chk("t1 rst data", out_data_a, 96'd0);
        chk("t1 rst nop b", out_data_b, 96'h13);
        for (int k = 1; k <= 4; k++) begin
            drive(1, 96'(k), 1, 0, 0);
            chk("t1 stream data", out_data_a, 96'(k));
            chk("t1 stream occ", {94'd0, occ_a}, 96'd1);
        end
        drive(0, 0, 1, 0, 0);
        chk("t1 drained", {94'd0, occ_a}, 96'd0);
        // 2: back-pressure absorbed by the skid entry
        drive(1, 96'hA0, 1, 0, 0);
        drive(1, 96'hA1, 1, 0, 0);
        chk("t2 head A1", out_data_a, 96'hA1);
        drive(1, 96'hA2, 0, 0, 0);
        chk("t2 full occ", {94'd0, occ_a}, 96'd2);
        chk("t2 full ready", {95'd0, in_ready_a}, 96'd0);
        chk("t2 head still A1", out_data_a, 96'hA1);
        out_ready = 1'b1;
        #1;
        chk("t2 no comb ready", {95'd0, in_ready_a}, 96'd0);
        drive(0, 0, 1, 0, 0);
        chk("t2 head A2", out_data_a, 96'hA2);
        chk("t2 w1 head A2", {95'd0, out_data_c}, 96'd0);
        drive(0, 0, 1, 0, 0);
        chk("t2 empty", {95'd0, out_valid_a}, 96'd0);
        // 3: flush while full with a same-cycle in_fire that must be discarded
        drive(1, 96'hB0, 0, 0, 0);
        drive(1, 96'hB1, 0, 0, 0);
        chk("t3 full", {94'd0, occ_a}, 96'd2);
        drive(1, 96'hB2, 0, 1, 0);
        chk("t3 flush valid", {95'd0, out_valid_a}, 96'd0);
        chk("t3 flush occ", {94'd0, occ_a}, 96'd0);
        chk("t3 flush nop", out_data_b, 96'h13);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("t3 B2 gone", {95'd0, out_valid_a}, 96'd0);
        // 4: simultaneous in/out fire holds ONE
        drive(1, 96'hC0, 1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(1, 96'hC0 + 96'(i), 1, 0, 0);
            chk("t4 occ", {94'd0, occ_a}, 96'd1);
            chk("t4 ready", {95'd0, in_ready_a}, 96'd1);
            chk("t4 data", out_data_a, 96'hC0 + 96'(i));
        end
        drive(0, 0, 1, 0, 0);
        // 5: reset while full with in_valid high
        drive(1, 96'hD0, 0, 0, 0);
        drive(1, 96'hD1, 0, 0, 0);
        drive(1, 96'hD2, 0, 0, 1);
        chk("t5 rst occ", {94'd0, occ_a}, 96'd0);
        chk("t5 rst nop b", out_data_b, 96'h13);
        chk("t5 rst nop c", {95'd0, out_data_c}, 96'd1);
        drive(1, 96'hE1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("t5 after rst", {95'd0, out_valid_a}, 96'd0);
        // mixed valid/ready patterns, checked against the model every cycle
        pv = 32'hDB6E_F5A7;
        pr = 32'h6C3A_9E51;
        for (int i = 0; i < 32; i++) drive(pv[i], 96'hF00 + 96'(i) * 96'h1_0000_0001, pr[i], 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        chk("final empty", {94'd0, occ_a}, 96'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
